// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_MISALIGN_EN adds the S_FAULT state used
// to park the fetch stage after a misaligned redirect.
package fetch_pkg;

  localparam int          XLEN_DEF = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int          PC_STEP  = 4;

  // Fetch controller states. S_FAULT only exists when misaligned redirects
  // are reported instead of silently aligned.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef FETCH_MISALIGN_EN
    ,
    S_FAULT = 2'd3
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage sitting directly in front of the decoder. Owns the
// PC, issues one word-aligned read at a time to instruction memory, holds the
// returned word for decode, and accepts control-flow redirects from execute.
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready request channel to instruction memory
//   imem_addr           byte address of the request (low 2 bits always 0)
//   imem_rsp_valid      read data valid, at the earliest one cycle after accept
//   imem_rdata          returned instruction word
//   inst, inst_pc       instruction and its PC presented to decode
//   inst_valid/ready    output handshake to decode
//   redirect_valid      take redirect_target as the next PC
//   redirect_target     new PC
//   fetch_misaligned    (FETCH_MISALIGN_EN only) stage parked on a misaligned
//                       redirect target
//
// Optional feature macro: FETCH_MISALIGN_EN. When undefined, redirect targets
// simply have their low two bits cleared.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state, stateNext;
  logic [XLEN-1:0] pc, pcNext;
  logic            kill, killNext;
  logic [XLEN-1:0] instReg, instNext;
  logic [XLEN-1:0] instPcReg, instPcNext;
  logic            instValidReg, instValidNext;
  logic [XLEN-1:0] targetPc;

  // Redirect target as it will be loaded into the PC. With the fault feature
  // the raw target is kept so the offending address is visible in the PC;
  // otherwise it is forced onto a word boundary.
`ifdef FETCH_MISALIGN_EN
  logic targetBad;
  assign targetPc  = redirect_target;
  assign targetBad = (redirect_target[1:0] != 2'b00);
`else
  assign targetPc  = redirect_target & ALIGN_MASK;
`endif

  // State register plus every piece of architectural state the fetch stage
  // owns. Reset abandons any in-flight request: kill is cleared and the
  // controller restarts in S_REQ, so a stale response lands in a state that
  // does not look at imem_rsp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      instReg      <= XLEN'(INST_NOP);
      instPcReg    <= RESET_PC;
      instValidReg <= 1'b0;
    end else begin
      state        <= stateNext;
      pc           <= pcNext;
      kill         <= killNext;
      instReg      <= instNext;
      instPcReg    <= instPcNext;
      instValidReg <= instValidNext;
    end
  end

  // Next-state and next-PC selection. A redirect always wins over the
  // sequential PC+4. kill marks a request that has been accepted but whose
  // response must be thrown away because the PC moved underneath it.
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    killNext      = kill;
    instNext      = instReg;
    instPcNext    = instPcReg;
    instValidNext = instValidReg;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pcNext = targetPc;
          if (imem_req_ready) begin
            stateNext = S_WAIT;
            killNext  = 1'b1;
          end
        end else if (imem_req_ready) begin
          stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pcNext = targetPc;
          if (imem_rsp_valid) begin
            killNext  = 1'b0;
            stateNext = S_REQ;
          end else begin
            killNext  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill) begin
            killNext  = 1'b0;
            stateNext = S_REQ;
          end else begin
            instNext      = imem_rdata;
            instPcNext    = pc;
            instValidNext = 1'b1;
            stateNext     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pcNext        = targetPc;
          instValidNext = 1'b0;
          stateNext     = S_REQ;
        end else if (inst_ready) begin
          pcNext        = pc + XLEN'(PC_STEP);
          instValidNext = 1'b0;
          stateNext     = S_REQ;
        end
      end
`ifdef FETCH_MISALIGN_EN
      S_FAULT: begin
        // A request may still be in flight if the fault was taken while it
        // was outstanding; its response is absorbed here. If it has not come
        // back by the time an aligned redirect arrives, wait for it in S_WAIT
        // (kill still set) so two requests are never outstanding.
        if (imem_rsp_valid) begin
          killNext = 1'b0;
        end
        if (redirect_valid) begin
          pcNext = targetPc;
          if (!targetBad) begin
            stateNext = (kill && !imem_rsp_valid) ? S_WAIT : S_REQ;
          end
        end
      end
`endif
      default: begin
        stateNext = S_REQ;
      end
    endcase
`ifdef FETCH_MISALIGN_EN
    // A misaligned redirect overrides the per-state decision and parks the
    // stage. The kill value chosen above already tracks any outstanding
    // request, so only the state and inst_valid need forcing.
    if (redirect_valid && targetBad) begin
      stateNext     = S_FAULT;
      instValidNext = 1'b0;
    end
`endif
  end

  // Outputs are decoded from the registered state only, so nothing here
  // depends combinationally on the handshake inputs.
  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_addr      = pc & ALIGN_MASK;
    inst           = instReg;
    inst_pc        = instPcReg;
    inst_valid     = instValidReg;
`ifdef FETCH_MISALIGN_EN
    fetch_misaligned = (state == S_FAULT);
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. A small memory model answers accepted
// requests after a configurable delay; accepted addresses and consumed
// instructions are logged and checked against expectations queued by each
// test. Build with FETCH_MISALIGN_EN to exercise the misaligned-redirect
// fault path.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Memory model state
  bit          pending;
  logic [31:0] pendAddr;
  int          countdown;
  int          rspDelay;

  // Scoreboard queues: expectations pushed by tests, observations by tick
  logic [31:0] expAddr[$];
  logic [31:0] obsAddr[$];
  logic [63:0] expInst[$];
  logic [63:0] obsInst[$];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rdata      (imem_rdata),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : ((a << 8) | 32'h13);
  endfunction

  // One clock cycle: sample handshakes at the falling edge, then after the
  // rising edge let the memory model drive its response for the new cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] accAddr;
    @(negedge clk);
    acc     = imem_req_valid && imem_req_ready && !reset;
    accAddr = imem_addr;
    if (acc) obsAddr.push_back(accAddr);
    if (inst_valid && inst_ready && !reset) obsInst.push_back({inst_pc, inst});
    @(posedge clk);
    #1;
    if (acc) begin
      pending   = 1'b1;
      pendAddr  = accAddr;
      countdown = rspDelay;
    end
    imem_rsp_valid = 1'b0;
    if (pending) begin
      if (countdown == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rdata     = memWord(pendAddr);
        pending        = 1'b0;
      end else begin
        countdown--;
      end
    end
  endtask

  task automatic doReset();
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    rspDelay        = 0;
    tick();
    tick();
    reset          = 1'b0;
    pending        = 1'b0;
    imem_rsp_valid = 1'b0;
    expAddr.delete();
    obsAddr.delete();
    expInst.delete();
    obsInst.delete();
  endtask

  task automatic test_reset();
    doReset();
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_inst_valid: got %b required 0", inst_valid); end
    vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_valid: got %b required 1", imem_req_valid); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h required 00000000", imem_addr); end
    vectors++; if (inst !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL reset_inst: got %h required 00000013", inst); end
    vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_inst_pc: got %h required 00000000", inst_pc); end
  endtask

  task automatic test_basic();
    logic [31:0] e, o;
    logic [63:0] ei, oi;
    doReset();
    expAddr.push_back(32'h0);
    expAddr.push_back(32'h4);
    expInst.push_back({32'h0, 32'h0050_0093});
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_wait_req: got %b required 0", imem_req_valid); end
    tick();
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_inst_valid: got %b required 1", inst_valid); end
    vectors++; if (inst !== 32'h0050_0093) begin miscompares++; $display("[TB] FAIL basic_inst: got %h required 00500093", inst); end
    vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL basic_inst_pc: got %h required 00000000", inst_pc); end
    tick();
    vectors++; if (imem_addr !== 32'h4 || imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_next_addr: got %h/%b required 00000004/1", imem_addr, imem_req_valid); end
    tick();
    imem_req_ready = 1'b0;
    while (expAddr.size() > 0) begin
      e = expAddr.pop_front(); vectors++;
      if (obsAddr.size() == 0) begin miscompares++; $display("[TB] FAIL basic_req_seq: got none required %h", e); end
      else begin o = obsAddr.pop_front(); if (o !== e) begin miscompares++; $display("[TB] FAIL basic_req_seq: got %h required %h", o, e); end end
    end
    while (expInst.size() > 0) begin
      ei = expInst.pop_front(); vectors++;
      if (obsInst.size() == 0) begin miscompares++; $display("[TB] FAIL basic_inst_seq: got none required %h", ei); end
      else begin oi = obsInst.pop_front(); if (oi !== ei) begin miscompares++; $display("[TB] FAIL basic_inst_seq: got %h required %h", oi, ei); end end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e, o;
    logic [63:0] ei, oi;
    doReset();
    expAddr.push_back(32'h0);
    expAddr.push_back(32'h4);
    expInst.push_back({32'h0, 32'h0050_0093});
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_hold_%0d: got valid=%b req=%b required valid=1 req=0", i, inst_valid, imem_req_valid); end
      vectors++; if (inst !== 32'h0050_0093 || inst_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL bp_stable_%0d: got %h@%h required 00500093@00000000", i, inst, inst_pc); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    vectors++; if (imem_addr !== 32'h4 || imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_next_addr: got %h/%b required 00000004/1", imem_addr, imem_req_valid); end
    tick();
    imem_req_ready = 1'b0;
    while (expAddr.size() > 0) begin
      e = expAddr.pop_front(); vectors++;
      if (obsAddr.size() == 0) begin miscompares++; $display("[TB] FAIL bp_req_seq: got none required %h", e); end
      else begin o = obsAddr.pop_front(); if (o !== e) begin miscompares++; $display("[TB] FAIL bp_req_seq: got %h required %h", o, e); end end
    end
    while (expInst.size() > 0) begin
      ei = expInst.pop_front(); vectors++;
      if (obsInst.size() == 0) begin miscompares++; $display("[TB] FAIL bp_inst_seq: got none required %h", ei); end
      else begin oi = obsInst.pop_front(); if (oi !== ei) begin miscompares++; $display("[TB] FAIL bp_inst_seq: got %h required %h", oi, ei); end end
    end
  endtask

  task automatic test_req_stall();
    logic [31:0] e, o;
    logic [63:0] ei, oi;
    doReset();
    expAddr.push_back(32'h100);
    expInst.push_back({32'h100, memWord(32'h100)});
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    tick();
    vectors++; if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_hold: got %h/%b/%b required 00000000/1/0", imem_addr, imem_req_valid, inst_valid); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid  = 1'b0;
    vectors++; if (imem_addr !== 32'h100 || imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_redirect: got %h/%b required 00000100/1", imem_addr, imem_req_valid); end
    tick();
    vectors++; if (imem_addr !== 32'h100 || imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_redirect_hold: got %h/%b required 00000100/1", imem_addr, imem_req_valid); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== memWord(32'h100)) begin miscompares++; $display("[TB] FAIL stall_inst: got %b %h@%h required 1 %h@00000100", inst_valid, inst, inst_pc, memWord(32'h100)); end
    tick();
    vectors++; if (imem_addr !== 32'h104 || imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_next_addr: got %h/%b required 00000104/1", imem_addr, imem_req_valid); end
    while (expAddr.size() > 0) begin
      e = expAddr.pop_front(); vectors++;
      if (obsAddr.size() == 0) begin miscompares++; $display("[TB] FAIL stall_req_seq: got none required %h", e); end
      else begin o = obsAddr.pop_front(); if (o !== e) begin miscompares++; $display("[TB] FAIL stall_req_seq: got %h required %h", o, e); end end
    end
    vectors++; if (obsAddr.size() != 0) begin miscompares++; $display("[TB] FAIL stall_req_extra: got %0d extra required 0", obsAddr.size()); end
    while (expInst.size() > 0) begin
      ei = expInst.pop_front(); vectors++;
      if (obsInst.size() == 0) begin miscompares++; $display("[TB] FAIL stall_inst_seq: got none required %h", ei); end
      else begin oi = obsInst.pop_front(); if (oi !== ei) begin miscompares++; $display("[TB] FAIL stall_inst_seq: got %h required %h", oi, ei); end end
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] e, o;
    logic [63:0] ei, oi;
    doReset();
    expAddr.push_back(32'h0);
    expAddr.push_back(32'h80);
    expInst.push_back({32'h80, memWord(32'h80)});
    rspDelay       = 1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    tick();
    redirect_valid  = 1'b0;
    vectors++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_wait: got valid=%b req=%b required 0/0", inst_valid, imem_req_valid); end
    tick();
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_dropped: got %b required 0", inst_valid); end
    vectors++; if (imem_addr !== 32'h80 || imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rw_next_addr: got %h/%b required 00000080/1", imem_addr, imem_req_valid); end
    rspDelay       = 0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst !== memWord(32'h80)) begin miscompares++; $display("[TB] FAIL rw_inst: got %b %h@%h required 1 %h@00000080", inst_valid, inst, inst_pc, memWord(32'h80)); end
    tick();
    while (expAddr.size() > 0) begin
      e = expAddr.pop_front(); vectors++;
      if (obsAddr.size() == 0) begin miscompares++; $display("[TB] FAIL rw_req_seq: got none required %h", e); end
      else begin o = obsAddr.pop_front(); if (o !== e) begin miscompares++; $display("[TB] FAIL rw_req_seq: got %h required %h", o, e); end end
    end
    while (expInst.size() > 0) begin
      ei = expInst.pop_front(); vectors++;
      if (obsInst.size() == 0) begin miscompares++; $display("[TB] FAIL rw_inst_seq: got none required %h", ei); end
      else begin oi = obsInst.pop_front(); if (oi !== ei) begin miscompares++; $display("[TB] FAIL rw_inst_seq: got %h required %h", oi, ei); end end
    end
    vectors++; if (obsInst.size() != 0) begin miscompares++; $display("[TB] FAIL rw_inst_extra: got %0d extra required 0", obsInst.size()); end
  endtask

  task automatic test_redirect_hold();
    logic [31:0] e, o;
    logic [63:0] ei, oi;
    doReset();
    expAddr.push_back(32'h10);
    expAddr.push_back(32'h40);
    expInst.push_back({32'h10, memWord(32'h10)});
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    tick();
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10) begin miscompares++; $display("[TB] FAIL rh_hold: got %b@%h required 1@00000010", inst_valid, inst_pc); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    inst_ready      = 1'b1;
    tick();
    redirect_valid  = 1'b0;
    inst_ready      = 1'b0;
    vectors++; if (imem_addr !== 32'h40 || imem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rh_priority: got %h/%b/%b required 00000040/1/0", imem_addr, imem_req_valid, inst_valid); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    while (expAddr.size() > 0) begin
      e = expAddr.pop_front(); vectors++;
      if (obsAddr.size() == 0) begin miscompares++; $display("[TB] FAIL rh_req_seq: got none required %h", e); end
      else begin o = obsAddr.pop_front(); if (o !== e) begin miscompares++; $display("[TB] FAIL rh_req_seq: got %h required %h", o, e); end end
    end
    while (expInst.size() > 0) begin
      ei = expInst.pop_front(); vectors++;
      if (obsInst.size() == 0) begin miscompares++; $display("[TB] FAIL rh_inst_seq: got none required %h", ei); end
      else begin oi = obsInst.pop_front(); if (oi !== ei) begin miscompares++; $display("[TB] FAIL rh_inst_seq: got %h required %h", oi, ei); end end
    end
  endtask

  task automatic test_reset_midflight();
    doReset();
    rspDelay       = 1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset          = 1'b1;
    tick();
    reset          = 1'b0;
    tick();
    vectors++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rm_stale_rsp: got %b/%b/%h required 0/1/00000000", inst_valid, imem_req_valid, imem_addr); end
    tick();
    vectors++; if (inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL rm_inst: got %b %h required 0 00000013", inst_valid, inst); end
  endtask

  task automatic test_misalign();
    logic [31:0] e, o;
    doReset();
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    tick();
    redirect_valid  = 1'b0;
`ifdef FETCH_MISALIGN_EN
    expAddr.push_back(32'h200);
    vectors++; if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_fault: got %b/%b/%b required 1/0/0", fetch_misaligned, imem_req_valid, inst_valid); end
    imem_req_ready = 1'b1;
    repeat (3) tick();
    vectors++; if (obsAddr.size() != 0 || imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_no_req: got %0d reqs req=%b required 0/0", obsAddr.size(), imem_req_valid); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h106;
    tick();
    vectors++; if (fetch_misaligned !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_keep: got %b required 1", fetch_misaligned); end
    redirect_target = 32'h200;
    tick();
    redirect_valid  = 1'b0;
    vectors++; if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("[TB] FAIL mis_clear: got %b/%b/%h required 0/1/00000200", fetch_misaligned, imem_req_valid, imem_addr); end
    tick();
    imem_req_ready = 1'b0;
`else
    expAddr.push_back(32'h100);
    vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL mis_align: got %b/%h required 1/00000100", imem_req_valid, imem_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL mis_align_inst: got %b@%h required 1@00000100", inst_valid, inst_pc); end
`endif
    while (expAddr.size() > 0) begin
      e = expAddr.pop_front(); vectors++;
      if (obsAddr.size() == 0) begin miscompares++; $display("[TB] FAIL mis_req_seq: got none required %h", e); end
      else begin o = obsAddr.pop_front(); if (o !== e) begin miscompares++; $display("[TB] FAIL mis_req_seq: got %h required %h", o, e); end end
    end
  endtask

  initial begin
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rdata      = 32'h0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    pending         = 1'b0;
    pendAddr        = 32'h0;
    countdown       = 0;
    rspDelay        = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_req_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_midflight();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
